// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between fetch and data requesters.
// One outstanding transaction; data has priority, with bounded starvation for fetch.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    input  logic [63:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_instr,

    input  logic        dm_req_valid,
    input  logic        dm_req_we,
    input  logic [63:0] dm_req_addr,
    input  logic [63:0] dm_req_wdata,
    output logic        dm_req_ready,
    output logic        dm_rsp_valid,
    output logic [63:0] dm_rsp_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,

    output logic        busy
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StWaitIf, StWaitDm} state_e;

    state_e      state_q;
    logic [3:0]  starve_cnt_q;
    logic        half_sel_q;
    logic        dm_we_q;
    logic        if_rsp_valid_q;
    logic        dm_rsp_valid_q;
    logic [31:0] if_rsp_instr_q;
    logic [63:0] dm_rsp_rdata_q;

    logic idle;
    logic grant_if;
    logic grant_dm;
    logic if_hs;
    logic dm_hs;

    // Fetch offset bits inside a 32-bit word carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^if_req_addr[1:0];

    assign idle     = (state_q == StIdle);
    // Fetch wins when alone, or once data has beaten it STARVE_MAX times in a row.
    assign grant_if = if_req_valid && (!dm_req_valid || (starve_cnt_q == StarveMax));
    assign grant_dm = dm_req_valid && !grant_if;
    assign if_hs    = idle && grant_if && mem_req_ready;
    assign dm_hs    = idle && grant_dm && mem_req_ready;

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = 64'd0;
        mem_req_wdata = 64'd0;
        if_req_ready  = 1'b0;
        dm_req_ready  = 1'b0;
        if (idle) begin
            mem_req_valid = grant_if || grant_dm;
            if (grant_if) begin
                mem_req_addr = {if_req_addr[63:3], 3'b000};
                if_req_ready = mem_req_ready;
            end else if (grant_dm) begin
                mem_req_we    = dm_req_we;
                mem_req_addr  = dm_req_addr;
                mem_req_wdata = dm_req_wdata;
                dm_req_ready  = mem_req_ready;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            starve_cnt_q   <= 4'd0;
            half_sel_q     <= 1'b0;
            dm_we_q        <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            if_rsp_instr_q <= 32'd0;
            dm_rsp_rdata_q <= 64'd0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_hs) begin
                        state_q      <= StWaitIf;
                        half_sel_q   <= if_req_addr[2];
                        starve_cnt_q <= 4'd0;
                    end else if (dm_hs) begin
                        state_q <= StWaitDm;
                        dm_we_q <= dm_req_we;
                        if (if_req_valid && (starve_cnt_q != StarveMax)) begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end
                end
                StWaitIf: begin
                    if (mem_rsp_valid) begin
                        state_q        <= StIdle;
                        if_rsp_valid_q <= 1'b1;
                        if_rsp_instr_q <= half_sel_q ? mem_rsp_rdata[63:32]
                                                     : mem_rsp_rdata[31:0];
                    end
                end
                StWaitDm: begin
                    if (mem_rsp_valid) begin
                        state_q        <= StIdle;
                        dm_rsp_valid_q <= 1'b1;
                        dm_rsp_rdata_q <= dm_we_q ? 64'd0 : mem_rsp_rdata;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_instr = if_rsp_instr_q;
    assign dm_rsp_valid = dm_rsp_valid_q;
    assign dm_rsp_rdata = dm_rsp_rdata_q;
    assign busy         = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, load/store, contention,
// backpressure, reset mid-transaction and spurious responses.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_instr;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [63:0] dm_req_addr;
    logic [63:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [63:0] dm_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        busy;

    int n_tests;
    int n_fail;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_instr (if_rsp_instr),
        .dm_req_valid (dm_req_valid),
        .dm_req_we    (dm_req_we),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_req_ready (dm_req_ready),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we   (mem_req_we),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; inputs are driven and outputs sampled there.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        if_req_valid  = 1'b0;
        if_req_addr   = 64'd0;
        dm_req_valid  = 1'b0;
        dm_req_we     = 1'b0;
        dm_req_addr   = 64'd0;
        dm_req_wdata  = 64'd0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        check("rst_dm_rsp_valid", 64'(dm_rsp_valid), 64'd0);
        check("rst_if_rsp_instr", 64'(if_rsp_instr), 64'd0);
        check("rst_dm_rsp_rdata", dm_rsp_rdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Lone fetch from the upper half of a doubleword
        if_req_valid = 1'b1;
        if_req_addr  = 64'h1004;
        #1;
        check("if_mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("if_mem_req_addr", mem_req_addr, 64'h1000);
        check("if_mem_req_we", 64'(mem_req_we), 64'd0);
        check("if_req_ready", 64'(if_req_ready), 64'd1);
        step();
        if_req_valid  = 1'b0;
        check("if_busy", 64'(busy), 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h11112222_33334444;
        step();
        mem_rsp_valid = 1'b0;
        check("if_rsp_valid", 64'(if_rsp_valid), 64'd1);
        check("if_rsp_instr", 64'(if_rsp_instr), 64'h11112222);
        check("if_idle_after", 64'(busy), 64'd0);
        step();
        check("if_rsp_pulse_end", 64'(if_rsp_valid), 64'd0);
        check("if_rsp_instr_hold", 64'(if_rsp_instr), 64'h11112222);

        // Load
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b0;
        dm_req_addr  = 64'h2000;
        #1;
        check("ld_mem_req_addr", mem_req_addr, 64'h2000);
        check("ld_dm_req_ready", 64'(dm_req_ready), 64'd1);
        step();
        dm_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hDEADBEEF_CAFEF00D;
        step();
        mem_rsp_valid = 1'b0;
        check("ld_dm_rsp_valid", 64'(dm_rsp_valid), 64'd1);
        check("ld_dm_rsp_rdata", dm_rsp_rdata, 64'hDEADBEEF_CAFEF00D);

        // Store issued while the load response pulse is still visible
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b1;
        dm_req_addr  = 64'h2008;
        dm_req_wdata = 64'h55;
        #1;
        check("st_mem_req_we", 64'(mem_req_we), 64'd1);
        check("st_mem_req_wdata", mem_req_wdata, 64'h55);
        check("st_mem_req_addr", mem_req_addr, 64'h2008);
        step();
        dm_req_valid  = 1'b0;
        dm_req_we     = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        check("st_dm_rsp_valid", 64'(dm_rsp_valid), 64'd1);
        check("st_dm_rsp_rdata", dm_rsp_rdata, 64'd0);
        step();

        // Contention: grant order DM,DM,DM,DM,IF repeating
        if_req_valid = 1'b1;
        if_req_addr  = 64'h3000;
        dm_req_valid = 1'b1;
        dm_req_addr  = 64'h4000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("cont_if_ready_%0d", i), 64'(if_req_ready), 64'(i % 5 == 4));
            check($sformatf("cont_dm_ready_%0d", i), 64'(dm_req_ready), 64'(i % 5 != 4));
            step();
            check($sformatf("cont_busy_if_ready_%0d", i), 64'(if_req_ready), 64'd0);
            mem_rsp_valid = 1'b1;
            step();
            mem_rsp_valid = 1'b0;
        end
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        step();

        // Backpressure from memory
        mem_req_ready = 1'b0;
        dm_req_valid  = 1'b1;
        dm_req_addr   = 64'h5000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_dm_ready_%0d", i), 64'(dm_req_ready), 64'd0);
            check($sformatf("bp_mem_valid_%0d", i), 64'(mem_req_valid), 64'd1);
            step();
            check($sformatf("bp_busy_%0d", i), 64'(busy), 64'd0);
        end
        mem_req_ready = 1'b1;
        #1;
        check("bp_dm_ready_rise", 64'(dm_req_ready), 64'd1);
        step();
        dm_req_valid = 1'b0;
        check("bp_busy_accept", 64'(busy), 64'd1);
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        step();

        // Push starvation count to STARVE_MAX, then reset in WAIT_DM
        if_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            mem_rsp_valid = 1'b1;
            step();
            mem_rsp_valid = 1'b0;
        end
        #1;
        check("rm_dm_wins_4th", 64'(dm_req_ready), 64'd1);
        step();
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        check("rm_busy_wait_dm", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("rm_busy_in_reset", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h1234;
        step();
        mem_rsp_valid = 1'b0;
        check("rm_no_dm_rsp", 64'(dm_rsp_valid), 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        // Cleared count means DM wins again instead of the starved fetch
        if_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        #1;
        check("rm_cnt_clear_dm", 64'(dm_req_ready), 64'd1);
        check("rm_cnt_clear_if", 64'(if_req_ready), 64'd0);
        step();
        if_req_valid  = 1'b0;
        dm_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hABCD;
        step();
        mem_rsp_valid = 1'b0;
        check("rm_post_rdata", dm_rsp_rdata, 64'hABCD);
        step();

        // Spurious response while idle
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h9999;
        step();
        mem_rsp_valid = 1'b0;
        check("sp_if_rsp", 64'(if_rsp_valid), 64'd0);
        check("sp_dm_rsp", 64'(dm_rsp_valid), 64'd0);
        check("sp_busy", 64'(busy), 64'd0);
        check("sp_rdata_hold", dm_rsp_rdata, 64'hABCD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that lets the fetch stage and the memory stage of the RV64I pipeline share one unified instruction/data memory. It accepts one request at a time from either requester over valid/ready handshakes, forwards it to the memory bus, waits for the memory response, and returns registered response data to the originating requester. Data requests have priority over fetches, with a bounded-starvation rule that guarantees forward progress for fetch.

## Interface
Parameters:
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins once; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req_valid  input  1  fetch request present.
- if_req_addr  input  64  fetch byte address; bits [1:0] ignored.
- if_req_ready  output  1  fetch request accepted this cycle when high with if_req_valid.
- if_rsp_valid  output  1  one-cycle pulse: fetch data valid.
- if_rsp_instr  output  32  fetched instruction.
- dm_req_valid  input  1  data request present.
- dm_req_we  input  1  1 = store, 0 = load.
- dm_req_addr  input  64  data byte address, forwarded unchanged.
- dm_req_wdata  input  64  store data.
- dm_req_ready  output  1  data request accepted this cycle.
- dm_rsp_valid  output  1  one-cycle pulse: data transaction complete (loads and stores).
- dm_rsp_rdata  output  64  load data; 0 for stores.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts request.
- mem_req_we  output  1  write enable to memory.
- mem_req_addr  output  64  address to memory; fetch addresses forced to 8-byte alignment (bits [2:0] = 0).
- mem_req_wdata  output  64  write data; 0 for fetches.
- mem_rsp_valid  input  1  memory response valid (one cycle per accepted request).
- mem_rsp_rdata  input  64  memory read data.
- busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT_IF, WAIT_DM. Exactly one outstanding memory transaction.
- IDLE grant: if only one requester valid, it wins; if both valid, DM wins unless starve_cnt == STARVE_MAX, then IF wins.
- In IDLE, mem_req_valid = winner's valid; mem_req_* muxed combinationally from winner; winner's ready = mem_req_ready; loser's ready = 0. Outside IDLE all req readies and mem_req_valid are 0.
- Handshake (winner valid & mem_req_ready) moves to WAIT_IF or WAIT_DM. On IF grant, if_req_addr[2] is captured as half-select; on DM grant, dm_req_we is captured.
- starve_cnt (4 bits): cleared on any IF handshake; incremented on a DM handshake while if_req_valid is high; saturates at STARVE_MAX; untouched otherwise.
- In WAIT_x, on mem_rsp_valid: register response and return to IDLE. if_rsp_instr = half-select ? mem_rsp_rdata[63:32] : mem_rsp_rdata[31:0]. dm_rsp_rdata = captured we ? 0 : mem_rsp_rdata.
- mem_rsp_valid while in IDLE is ignored (no response pulse, no state change).
- Requesters must hold valid and payload stable until ready; arbiter does not buffer unaccepted requests.

## Timing
- Reset (rst low, asynchronous): state = IDLE, starve_cnt = 0, if_rsp_valid = dm_rsp_valid = 0, if_rsp_instr = 0, dm_rsp_rdata = 0, busy = 0; combinational readies/mem_req_valid follow IDLE rules from inputs. Reset mid-transaction abandons it; a late mem_rsp_valid is dropped.
- Response latency: x_rsp_valid rises the cycle after mem_rsp_valid; state is IDLE in that same cycle, so a new request may be accepted while the previous response pulse is visible.
- Best-case throughput: one transaction per (memory latency + 1) cycles; with zero-wait memory (rsp one cycle after accept), one transaction every 2 cycles.
- Response data outputs hold last value between pulses.

## Test plan
- Lone fetch: if_req_addr=0x1004, memory returns 0x11112222_33334444 one cycle after accept -> mem_req_addr=0x1000, if_rsp_valid pulse 2 cycles after accept, if_rsp_instr=0x11112222.
- Load then store: load 0x2000 returns 0xDEADBEEF_CAFEF00D -> dm_rsp_rdata=0xDEADBEEFCAFEF00D; store 0x2008 wdata=0x55 -> mem_req_we=1, mem_req_wdata=0x55, dm_rsp_valid pulse with dm_rsp_rdata=0.
- Contention, STARVE_MAX=4: both valid continuously -> grant sequence DM,DM,DM,DM,IF, repeating; if_req_ready never high while busy.
- Backpressure: mem_req_ready low 3 cycles with dm_req_valid high -> dm_req_ready low, state stays IDLE, accept on cycle mem_req_ready rises.
- Reset mid-transaction: assert rst in WAIT_DM, deassert, then pulse mem_rsp_valid -> no dm_rsp_valid, busy=0, starve_cnt=0.
- Spurious response: mem_rsp_valid in IDLE with no requests -> no rsp pulses, state stays IDLE.
